// File: rtl/gate_ctrl_if.sv
// Measurement handshake between the frequency-meter sequencer and the
// gate-window controller: run request and range select in, gate level,
// counter clear, latch strobe and status out.
interface gate_ctrl_if;
   logic       RUN;
   logic [1:0] RANGE;
   logic       GATE;
   logic       CNT_nCLR;
   logic       LATCH;
   logic       BUSY;
   logic [1:0] RANGE_Q;

   // Sequencer side: requests measurements, observes the strobes.
   modport master (
      output RUN, RANGE,
      input  GATE, CNT_nCLR, LATCH, BUSY, RANGE_Q
   );

   // Controller side.
   modport slave (
      input  RUN, RANGE,
      output GATE, CNT_nCLR, LATCH, BUSY, RANGE_Q
   );
endinterface

// File: rtl/gate_ctrl.sv
// Gate-window controller. Each measurement runs
// clear (2 cycles) -> gate open (G cycles) -> settle -> latch (1 cycle),
// where G = MS_TICKS x {1000,100,10,1}[RANGE_Q]. Every output comes
// straight from a flop so the enable flop and counters see glitch-free
// levels; the async reset drops GATE without waiting for CLK.
module gate_ctrl #(
   parameter int unsigned MS_TICKS   = 50000,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic         CLK,
   input  logic         nCLR,
   gate_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_GATE,
      S_SETTLE,
      S_LATCH
   } state_t;

   localparam logic [31:0] CLEAR_LAST  = 32'd1;
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);

   state_t      state_q, state_d;
   logic [31:0] tick_q, tick_d;
   logic [1:0]  range_sel_q, range_sel_d;
   logic        gate_q, gate_d;
   logic        cnt_nclr_q, cnt_nclr_d;
   logic        latch_q, latch_d;
   logic        busy_q, busy_d;

   // Gate lengths per range, full 32-bit products of constants.
   logic [31:0] g_term [4];
   logic [31:0] g_last;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_gate_len
         localparam int unsigned DECADE = (gi == 0) ? 1000 :
                                          (gi == 1) ? 100  :
                                          (gi == 2) ? 10   : 1;
         assign g_term[gi] = 32'(MS_TICKS * DECADE);
      end
   endgenerate

   assign g_last = g_term[range_sel_q] - 32'd1;

   // Next-state, tick reload on every state change, and output decode
   // from the next state so the outputs can be registered.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q + 32'd1;
      range_sel_d = range_sel_q;
      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (bus.RUN) begin
               state_d     = S_CLEAR;
               range_sel_d = bus.RANGE;
            end
         end
         S_CLEAR: begin
            if (tick_q == CLEAR_LAST) begin
               state_d = S_GATE;
               tick_d  = '0;
            end
         end
         S_GATE: begin
            if (tick_q == g_last) begin
               state_d = S_SETTLE;
               tick_d  = '0;
            end
         end
         S_SETTLE: begin
            if (tick_q == SETTLE_LAST) begin
               state_d = S_LATCH;
               tick_d  = '0;
            end
         end
         S_LATCH: begin
            tick_d = '0;
            if (bus.RUN) begin
               state_d     = S_CLEAR;
               range_sel_d = bus.RANGE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            tick_d  = '0;
         end
      endcase
      gate_d     = (state_d == S_GATE);
      cnt_nclr_d = (state_d != S_CLEAR);
      latch_d    = (state_d == S_LATCH);
      busy_d     = (state_d != S_IDLE);
   end

   // State, counter and output registers; nCLR kills everything at once.
   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         range_sel_q <= '0;
         gate_q      <= 1'b0;
         cnt_nclr_q  <= 1'b1;
         latch_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         range_sel_q <= range_sel_d;
         gate_q      <= gate_d;
         cnt_nclr_q  <= cnt_nclr_d;
         latch_q     <= latch_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.GATE     = gate_q;
   assign bus.CNT_nCLR = cnt_nclr_q;
   assign bus.LATCH    = latch_q;
   assign bus.BUSY     = busy_q;
   assign bus.RANGE_Q  = range_sel_q;

endmodule
